// File: rtl/tube_render_pkg.sv
// Shared constants for the tube renderer and its helpers.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: screen geometry, colour constants, LFSR shape, BCD digit width.
package tube_render_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Colours are RRR_GGG_BB.
    localparam logic [7:0] TUBE_RGB_DEFAULT = 8'b000_111_00;
    localparam logic [7:0] BLACK            = 8'h00;

    // x^7 + x^6 + 1: newest bit = q[6] ^ q[0], shifted in at the LSB.
    localparam int             LFSR_W      = 7;
    localparam int             LFSR_TAP_HI = 6;
    localparam int             LFSR_TAP_LO = 0;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

    localparam int BCD_W = 4;

endpackage

// File: rtl/tube_render_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR, period 127, never reaches zero.
// Latency: new value every cycle; seed visible during and right after reset.
// Backpressure: none, always advances.
// Ports: clk, reset (sync, active-high), q[6:0] current state.
module lfsr7
    import tube_render_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/tube_render.sv
// Tube renderer: random gap capture, frame-stable latch, pixel hit test, BCD score.
// Latency: tube_on/tube_rgb 1 cycle after pixel_x/pixel_y/video_on; score 1 cycle after termina rise.
// Backpressure: none; every output is registered and updates each cycle.
// Ports: clk, reset, random, posx, termina, frame_tick, pixel_x/y, video_on in;
//        tube_on, tube_rgb, gap_top, score_bcd, score_tick out.
module tube_render
    import tube_render_pkg::*;
#(
    parameter int         TUBE_W    = 40,
    parameter int         GAP_H     = 120,
    parameter int         GAP_MIN   = 40,
    parameter int         GAP_RESET = 100,
    parameter logic [7:0] TUBE_RGB  = TUBE_RGB_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       random,
    input  logic [9:0] posx,
    input  logic       termina,
    input  logic       frame_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    output logic       tube_on,
    output logic [7:0] tube_rgb,
    output logic [9:0] gap_top,
    output logic [7:0] score_bcd,
    output logic       score_tick
);

    logic [LFSR_W-1:0] lfsr;
    logic [9:0]        gap_pending;
    logic [9:0]        gap_q;
    logic [9:0]        posx_q;
    logic              termina_d;
    logic [BCD_W-1:0]  ones;
    logic [BCD_W-1:0]  tens;

    lfsr7 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    // Gap capture and once-per-frame latch. On a coincident random and
    // frame_tick the latch takes the previous pending gap; the new one
    // shows up a frame later, which keeps the visible gap tear-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_pending <= 10'(GAP_RESET);
            gap_q       <= 10'(GAP_RESET);
            posx_q      <= 10'(H_ACTIVE);
        end else begin
            if (random) begin
                gap_pending <= 10'(GAP_MIN) + {3'b0, lfsr};
            end
            if (frame_tick) begin
                posx_q <= posx;
                gap_q  <= gap_pending;
            end
        end
    end

    assign gap_top = gap_q;

    // 11-bit compares so posx_q + TUBE_W past the right edge clips rather
    // than wrapping back to column 0; posx_q = 640 therefore draws nothing.
    logic [10:0] x_pix, x_lo, x_hi, y_pix, y_lo, y_hi;
    logic        in_x, in_y, hit;

    always_comb begin
        x_pix = {1'b0, pixel_x};
        x_lo  = {1'b0, posx_q};
        x_hi  = x_lo + 11'(TUBE_W);
        y_pix = {1'b0, pixel_y};
        y_lo  = {1'b0, gap_q};
        y_hi  = y_lo + 11'(GAP_H);
        in_x  = (x_pix >= x_lo) && (x_pix < x_hi);
        in_y  = (y_pix < y_lo) || (y_pix >= y_hi);
        hit   = video_on && in_x && in_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tube_on  <= 1'b0;
            tube_rgb <= BLACK;
        end else begin
            tube_on  <= hit;
            tube_rgb <= hit ? TUBE_RGB : BLACK;
        end
    end

    // Score: one count per rising edge of termina, so a long-held level
    // counts once. BCD 99 rolls over to 00.
    logic termina_rise;
    assign termina_rise = termina && !termina_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            termina_d  <= 1'b0;
            ones       <= '0;
            tens       <= '0;
            score_tick <= 1'b0;
        end else begin
            termina_d  <= termina;
            score_tick <= termina_rise;
            if (termina_rise) begin
                if (ones == 4'd9) begin
                    ones <= '0;
                    tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

    assign score_bcd = {tens, ones};

endmodule

// File: tb/tb_tube_render.sv
module tb_tube_render;

    logic       clk = 1'b0;
    logic       reset, random, termina, frame_tick, video_on;
    logic [9:0] posx, pixel_x, pixel_y;
    logic       tube_on, score_tick;
    logic [7:0] tube_rgb, score_bcd;
    logic [9:0] gap_top;

    tube_render dut (
        .clk        (clk),
        .reset      (reset),
        .random     (random),
        .posx       (posx),
        .termina    (termina),
        .frame_tick (frame_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .tube_on    (tube_on),
        .tube_rgb   (tube_rgb),
        .gap_top    (gap_top),
        .score_bcd  (score_bcd),
        .score_tick (score_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       on;
        logic [7:0] rgb;
        logic [9:0] gap;
        logic [7:0] bcd;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: plain integers following the behavioural rules.
    logic [6:0] seq [127];
    int m_n, m_pend, m_gapq, m_posx, m_td, m_score;

    task automatic cmp(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // LFSR sequence from the bit-stream recurrence s[k] = s[k-1] ^ s[k-7].
    initial begin
        bit b [0:133];
        for (int k = 0; k < 7; k++) b[k] = (k == 6);
        for (int k = 7; k < 134; k++) b[k] = b[k-1] ^ b[k-7];
        for (int n = 0; n < 127; n++) begin
            seq[n] = '0;
            for (int i = 0; i < 7; i++) seq[n][i] = b[n+6-i];
        end
    end

    // Apply current inputs for one clock: predict, queue, advance.
    task automatic step();
        exp_t e;
        int   in_x, in_y, hit, rise;
        if (reset) begin
            m_n = 0; m_pend = 100; m_gapq = 100; m_posx = 640; m_td = 0; m_score = 0;
            e.on = 0; e.rgb = 0; e.tick = 0;
        end else begin
            in_x = (int'(pixel_x) >= m_posx) && (int'(pixel_x) < m_posx + 40);
            in_y = (int'(pixel_y) < m_gapq) || (int'(pixel_y) >= m_gapq + 120);
            hit  = video_on && in_x && in_y;
            rise = termina && !m_td;
            e.on  = hit[0];
            e.rgb = hit ? 8'b000_111_00 : 8'h00;
            e.tick = rise[0];
            if (rise) m_score = (m_score + 1) % 100;
            if (frame_tick) begin
                m_posx = int'(posx);
                m_gapq = m_pend;
            end
            if (random) m_pend = 40 + int'(seq[m_n]);
            m_n  = (m_n + 1) % 127;
            m_td = int'(termina);
        end
        e.gap = 10'(m_gapq);
        e.bcd = 8'(((m_score / 10) << 4) | (m_score % 10));
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs update every cycle, so one expected entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({tube_on, tube_rgb, gap_top, score_bcd, score_tick} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got on=%0b rgb=%h gap=%0d bcd=%h tick=%0b expected on=%0b rgb=%h gap=%0d bcd=%h tick=%0b at %0t",
                             tube_on, tube_rgb, gap_top, score_bcd, score_tick,
                             e.on, e.rgb, e.gap, e.bcd, e.tick, $time);
                end
            end
        end
    end

    task automatic idle();
        random = 0; frame_tick = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle(); termina = 0;
        step(); step();
        reset = 0;
    endtask

    task automatic latch(input int px);
        posx = 10'(px); frame_tick = 1; step(); frame_tick = 0;
    endtask

    task automatic pix(input int x, input int y);
        pixel_x = 10'(x); pixel_y = 10'(y); step();
    endtask

    task automatic pulse();
        termina = 1; step(); termina = 0; step();
    endtask

    int tx [7] = '{199, 200, 239, 240, 220, 220, 220};
    int ty [7] = '{50,  50,  99,  99,  100, 219, 220};
    int te [7] = '{0,   1,   1,   0,   0,   0,   1};
    int ticks;

    initial begin
        reset = 1; random = 0; termina = 0; frame_tick = 0; video_on = 1;
        posx = 10'd640; pixel_x = 0; pixel_y = 0;

        // 1: after reset nothing is drawn anywhere in the frame.
        do_reset();
        cmp("reset_gap", gap_top, 100);
        cmp("reset_score", score_bcd, 0);
        cmp("reset_tube", tube_on, 0);
        frame_tick = 1; posx = 10'd640;
        for (int y = 0; y < 480; y += 5) begin
            for (int x = 0; x < 640; x += 2) begin
                pix(x, y);
                frame_tick = 0;
            end
        end

        // 2: random on the fourth cycle after release captures lfsr = 0F.
        do_reset();
        step(); step(); step();
        random = 1; step(); random = 0;
        latch(640);
        cmp("gap_lfsr_0F", gap_top, 55);

        // 3: drawing, gap edges, blanking and right-edge clipping.
        do_reset();
        latch(200);
        for (int i = 0; i < 7; i++) begin
            pix(tx[i], ty[i]);
            cmp($sformatf("pix_%0d_%0d", tx[i], ty[i]), tube_on, te[i]);
        end
        video_on = 0;
        for (int i = 0; i < 7; i++) begin
            pix(tx[i], ty[i]);
            cmp("blank_pix", tube_on, 0);
        end
        video_on = 1;
        latch(620);
        pix(620, 10); cmp("clip_620", tube_on, 1);
        pix(639, 10); cmp("clip_639", tube_on, 1);
        pix(619, 10); cmp("clip_619", tube_on, 0);
        for (int x = 0; x < 20; x++) begin
            pix(x, 10);
            cmp("no_wrap", tube_on, 0);
        end

        // 4: coincident random + frame_tick keeps the old pending gap.
        posx = 10'd200; random = 1; frame_tick = 1; step(); idle();
        cmp("coincide_gap", gap_top, 100);
        posx = 10'd300;
        pix(310, 50); cmp("posx_ignored", tube_on, 0);
        pix(210, 50); cmp("posx_held", tube_on, 1);
        latch(300);
        cmp("next_frame_gap", gap_top, m_gapq);
        cmp("next_frame_gap_changed", gap_top != 100, 1);

        // 5: score counting.
        do_reset();
        ticks = 0; termina = 1;
        for (int i = 0; i < 500; i++) begin
            step();
            ticks += score_tick;
        end
        termina = 0; step();
        cmp("held_ticks", ticks, 1);
        cmp("held_score", score_bcd, 8'h01);
        for (int i = 0; i < 8; i++) pulse();
        cmp("score_09", score_bcd, 8'h09);
        pulse();
        cmp("score_10", score_bcd, 8'h10);
        for (int i = 0; i < 9; i++) pulse();
        cmp("score_19", score_bcd, 8'h19);
        for (int i = 0; i < 80; i++) pulse();
        cmp("score_99", score_bcd, 8'h99);
        pulse();
        cmp("score_wrap", score_bcd, 8'h00);

        // 6: reset mid-line clears drawing, score and gap.
        do_reset();
        for (int i = 0; i < 42; i++) pulse();
        latch(200);
        pix(220, 50);
        cmp("pre_reset_on", tube_on, 1);
        cmp("pre_reset_score", score_bcd, 8'h42);
        termina = 1; reset = 1; pix(221, 50); reset = 0; termina = 0;
        cmp("mid_reset_on", tube_on, 0);
        cmp("mid_reset_score", score_bcd, 8'h00);
        cmp("mid_reset_gap", gap_top, 100);
        for (int i = 0; i < 5; i++) begin
            pix(220 + i, 50);
            cmp("post_reset_blank", tube_on, 0);
        end
        latch(200);
        pix(220, 50); cmp("relatched_on", tube_on, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 499) == 0);
            random     = ($urandom_range(0, 19) == 0);
            frame_tick = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) termina = ~termina;
            video_on   = ($urandom_range(0, 7) != 0);
            posx       = ($urandom_range(0, 3) == 0) ? 10'd640 : 10'($urandom_range(0, 640));
            pixel_x    = 10'($urandom_range(0, 639));
            pixel_y    = 10'($urandom_range(0, 479));
            step();
        end
        reset = 0; idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
